// File: rtl/dcache_ctrl_if.sv
// rtl/dcache_ctrl_if.sv - CPU request and line-memory handshake bundle for the data cache
interface dcache_ctrl_if #(
  parameter int WORD_SIZE = 16
);
  logic                 cpu_read;
  logic                 cpu_write;
  logic [WORD_SIZE-1:0] cpu_address;
  logic [WORD_SIZE-1:0] cpu_wdata;
  logic [WORD_SIZE-1:0] cpu_rdata;
  logic                 cpu_ready;
  logic                 d_readM;
  logic                 d_writeM;
  logic [WORD_SIZE-1:0] d_address;

  // Environment side: the CPU issues requests, the memory observes line requests.
  modport master (
    output cpu_read, cpu_write, cpu_address, cpu_wdata,
    input  cpu_rdata, cpu_ready, d_readM, d_writeM, d_address
  );

  // Cache side.
  modport slave (
    input  cpu_read, cpu_write, cpu_address, cpu_wdata,
    output cpu_rdata, cpu_ready, d_readM, d_writeM, d_address
  );
endinterface

// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - direct-mapped write-back write-allocate data cache controller
module dcache_ctrl #(
  parameter int WORD_SIZE   = 16,
  parameter int LINE_SIZE   = 64,
  parameter int NUM_LINES   = 4,
  parameter int MEM_LATENCY = 4
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  dcache_ctrl_if.slave         bus,
  inout  wire  [LINE_SIZE-1:0] io_d_data,
  output logic [WORD_SIZE-1:0] o_hit_count,
  output logic [WORD_SIZE-1:0] o_miss_count
);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = WORD_SIZE - IDX_W - 2;
  localparam logic [2:0] LAST_CNT = 3'(MEM_LATENCY);
  localparam logic [WORD_SIZE-1:0] CNT_MAX = '1;
  localparam logic [WORD_SIZE-1:0] CNT_ONE = {{(WORD_SIZE-1){1'b0}}, 1'b1};

  // GAP is the single idle bus cycle between a write-back and the refill,
  // needed because memory only samples requests from its reset state.
  typedef enum logic [1:0] {S_IDLE, S_EVICT, S_GAP, S_FILL} state_t;

  state_t r_state;
  state_t w_next;

  logic [NUM_LINES-1:0] r_valid;
  logic [NUM_LINES-1:0] r_dirty;
  logic [TAG_W-1:0]     r_tag  [NUM_LINES];
  logic [LINE_SIZE-1:0] r_data [NUM_LINES];

  logic [2:0]           r_timer;
  logic                 r_readm;
  logic                 r_writem;
  logic                 r_drive;
  logic [WORD_SIZE-1:0] r_daddr;
  logic [LINE_SIZE-1:0] r_wb_line;
  logic [WORD_SIZE-1:0] r_rdata;
  logic [WORD_SIZE-1:0] r_hits;
  logic [WORD_SIZE-1:0] r_misses;
  logic                 r_refilled;

  logic                 w_req;
  logic [1:0]           w_off;
  logic [IDX_W-1:0]     w_index;
  logic [TAG_W-1:0]     w_tag;
  logic [LINE_SIZE-1:0] w_line;
  logic [LINE_SIZE-1:0] w_store_line;
  logic [WORD_SIZE-1:0] w_word;
  logic [WORD_SIZE-1:0] w_rdata;
  logic                 w_hit;
  logic                 w_ready;
  logic                 w_timer_done;
  logic                 w_idle_hit;
  logic                 w_idle_miss;
  logic                 w_evict_done;
  logic                 w_fill_done;

  assign w_req   = bus.cpu_read | bus.cpu_write;
  assign w_off   = bus.cpu_address[1:0];
  assign w_index = bus.cpu_address[IDX_W+1:2];
  assign w_tag   = bus.cpu_address[WORD_SIZE-1:IDX_W+2];
  assign w_line  = r_data[w_index];
  assign w_hit   = r_valid[w_index] && (r_tag[w_index] == w_tag);
  assign w_word  = w_line[int'(w_off)*WORD_SIZE +: WORD_SIZE];

  assign w_timer_done = (r_timer == LAST_CNT);
  assign w_idle_hit   = (r_state == S_IDLE) && w_req && w_hit;
  assign w_idle_miss  = (r_state == S_IDLE) && w_req && !w_hit;
  assign w_evict_done = (r_state == S_EVICT) && w_timer_done;
  assign w_fill_done  = (r_state == S_FILL) && w_timer_done;

  // Load data follows the selected word on a load hit, otherwise holds the last value.
  assign w_rdata = (w_idle_hit && bus.cpu_read) ? w_word : r_rdata;

  // Line image with the store word merged in, written back on a store hit.
  always_comb begin
    w_store_line = w_line;
    w_store_line[int'(w_off)*WORD_SIZE +: WORD_SIZE] = bus.cpu_wdata;
  end

  assign bus.cpu_ready = w_ready;
  assign bus.cpu_rdata = w_rdata;
  assign bus.d_readM   = r_readm;
  assign bus.d_writeM  = r_writem;
  assign bus.d_address = r_daddr;
  assign io_d_data     = r_drive ? r_wb_line : 'z;
  assign o_hit_count   = r_hits;
  assign o_miss_count  = r_misses;

  // State register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and CPU handshake decode.
  always_comb begin
    w_next  = r_state;
    w_ready = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          if (w_hit) begin
            w_ready = 1'b1;
          end else if (r_valid[w_index] && r_dirty[w_index]) begin
            w_next = S_EVICT;
          end else begin
            w_next = S_FILL;
          end
        end
      end
      S_EVICT: begin
        if (w_timer_done) begin
          w_next = S_GAP;
        end
      end
      S_GAP: begin
        w_next = S_FILL;
      end
      S_FILL: begin
        if (w_timer_done) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Memory-side strobes, address, write-back data and the transfer timer.
  // Strobes are registered from the next state so they are high exactly while
  // the FSM sits in EVICT or FILL.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_timer   <= 3'd0;
      r_readm   <= 1'b0;
      r_writem  <= 1'b0;
      r_drive   <= 1'b0;
      r_daddr   <= '0;
      r_wb_line <= '0;
    end else begin
      if (w_next != r_state) begin
        r_timer <= 3'd0;
      end else if (r_state == S_EVICT || r_state == S_FILL) begin
        r_timer <= r_timer + 3'd1;
      end
      r_readm  <= (w_next == S_FILL);
      r_writem <= (w_next == S_EVICT);
      r_drive  <= (w_next == S_EVICT);
      if (r_state == S_IDLE && w_next == S_EVICT) begin
        r_daddr   <= {r_tag[w_index], w_index, 2'b00};
        r_wb_line <= w_line;
      end
      if (r_state != S_FILL && w_next == S_FILL) begin
        r_daddr <= {w_tag, w_index, 2'b00};
      end
    end
  end

  // Valid and dirty bits: stores mark dirty, write-back cleans, refill validates.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else begin
      if (w_idle_hit && bus.cpu_write) begin
        r_dirty[w_index] <= 1'b1;
      end
      if (w_evict_done) begin
        r_dirty[w_index] <= 1'b0;
      end
      if (w_fill_done) begin
        r_valid[w_index] <= 1'b1;
        r_dirty[w_index] <= 1'b0;
      end
    end
  end

  // Tag and data storage; contents are meaningless until the valid bit is set.
  always_ff @(posedge i_clk) begin
    if (w_idle_hit && bus.cpu_write) begin
      r_data[w_index] <= w_store_line;
    end
    if (w_fill_done) begin
      r_data[w_index] <= io_d_data;
      r_tag[w_index]  <= w_tag;
    end
  end

  // Saturating hit/miss counters and the held load data. The first IDLE cycle
  // after a refill completes the original missed request, so it is not a new hit.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_hits     <= '0;
      r_misses   <= '0;
      r_rdata    <= '0;
      r_refilled <= 1'b0;
    end else begin
      r_rdata    <= w_rdata;
      r_refilled <= w_fill_done;
      if (w_idle_hit && !r_refilled && r_hits != CNT_MAX) begin
        r_hits <= r_hits + CNT_ONE;
      end
      if (w_idle_miss && r_misses != CNT_MAX) begin
        r_misses <= r_misses + CNT_ONE;
      end
    end
  end
endmodule

// File: tb/tb_dcache_ctrl.sv
// tb/tb_dcache_ctrl.sv - self-checking bench for dcache_ctrl
module tb_dcache_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  wire  [63:0] d_data;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  dcache_ctrl_if #(.WORD_SIZE(16)) bus ();

  dcache_ctrl #(
    .WORD_SIZE(16), .LINE_SIZE(64), .NUM_LINES(4), .MEM_LATENCY(4)
  ) dut (
    .i_clk(clk), .i_reset(rst), .bus(bus), .io_d_data(d_data),
    .o_hit_count(hit_count), .o_miss_count(miss_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] init_line(input int i);
    if (i == 0) return 64'h0000_FFFF_0001_9023;
    if (i == 4) return 64'hAAAA_BBBB_CCCC_DDDD;
    return {16'(i * 7 + 1), 16'(i ^ 'h5A5A), 16'(i * 13), 16'(~i)};
  endfunction

  // Line memory: samples a request when idle, then FETCH0..FETCH3; read data
  // is driven in FETCH3, write data is committed at the edge ending FETCH3.
  logic [63:0] mem [16384];
  int          m_phase;
  logic        m_wr;
  logic [13:0] m_line;
  bit          m_loaded;

  assign d_data = (m_phase == 4 && !m_wr) ? mem[m_line] : 'z;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase <= 0;
      if (!m_loaded) begin
        for (int i = 0; i < 16384; i++) mem[i] <= init_line(i);
        m_loaded <= 1'b1;
      end
    end else begin
      case (m_phase)
        0: if (bus.d_readM || bus.d_writeM) begin
          m_phase <= 1;
          m_wr    <= bus.d_writeM;
          m_line  <= bus.d_address[15:2];
        end
        4: begin
          if (m_wr) mem[m_line] <= d_data;
          m_phase <= 0;
        end
        default: m_phase <= m_phase + 1;
      endcase
    end
  end

  // Reference model: what the cache should hold, and what memory should hold.
  logic [63:0] ref_mem [16384];
  logic        m_valid [4];
  logic        m_dirty [4];
  logic [11:0] m_tag   [4];
  logic [63:0] m_lines [4];
  int          m_hits;
  int          m_misses;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
    m_hits   = 0;
    m_misses = 0;
  endtask

  task automatic model_access(input bit wr, input logic [15:0] addr, input logic [15:0] wd,
                              output int lat, output logic [15:0] rd,
                              output logic [15:0] ev, output logic [15:0] fl);
    logic [1:0]  idx;
    logic [1:0]  off;
    logic [11:0] tag;
    logic [63:0] ln;
    idx = addr[3:2];
    off = addr[1:0];
    tag = addr[15:4];
    ev  = 16'h0000;
    fl  = {addr[15:2], 2'b00};
    if (m_valid[idx] && m_tag[idx] == tag) begin
      lat = 0;
      if (m_hits < 65535) m_hits++;
    end else begin
      if (m_misses < 65535) m_misses++;
      lat = 6;
      if (m_valid[idx] && m_dirty[idx]) begin
        lat = 12;
        ev  = {m_tag[idx], idx, 2'b00};
        ref_mem[{m_tag[idx], idx}] = m_lines[idx];
      end
      m_lines[idx] = ref_mem[addr[15:2]];
      m_valid[idx] = 1'b1;
      m_dirty[idx] = 1'b0;
      m_tag[idx]   = tag;
    end
    ln = m_lines[idx];
    rd = ln[int'(off)*16 +: 16];
    if (wr) begin
      ln[int'(off)*16 +: 16] = wd;
      m_lines[idx] = ln;
      m_dirty[idx] = 1'b1;
    end
  endtask

  // Issues one request (called just after a rising edge) and follows it to
  // completion. Expected bus activity per cycle k after the request cycle:
  // clean miss reads on 1..5; dirty miss writes on 1..5, idle on 6, reads on 7..11.
  task automatic cpu_op(input bit wr, input logic [15:0] addr, input logic [15:0] wd,
                        input int exp_lat, input logic [15:0] exp_rd,
                        input logic [15:0] exp_ev, input logic [15:0] exp_fl,
                        input int exp_hits, input int exp_misses);
    int k;
    bit done;
    int bus_err;
    bit exp_r;
    bit exp_w;
    bus.cpu_read    = !wr;
    bus.cpu_write   = wr;
    bus.cpu_address = addr;
    bus.cpu_wdata   = wd;
    k = 0;
    done = 1'b0;
    bus_err = 0;
    while (!done && k < 40) begin
      @(negedge clk);
      exp_r = (exp_lat == 6 && k >= 1 && k <= 5) || (exp_lat == 12 && k >= 7 && k <= 11);
      exp_w = (exp_lat == 12 && k >= 1 && k <= 5);
      if (bus.d_readM !== exp_r || bus.d_writeM !== exp_w) bus_err++;
      else if (exp_r && bus.d_address !== exp_fl) bus_err++;
      else if (exp_w && bus.d_address !== exp_ev) bus_err++;
      if (bus.cpu_ready) done = 1'b1;
      else k++;
    end
    check("latency", 64'(k), 64'(exp_lat));
    if (!wr && done) check("rdata", 64'(bus.cpu_rdata), 64'(exp_rd));
    check("bus_sequence_errors", 64'(bus_err), 64'd0);
    @(posedge clk);
    #1;
    bus.cpu_read  = 1'b0;
    bus.cpu_write = 1'b0;
    check("hit_count", 64'(hit_count), 64'(exp_hits));
    check("miss_count", 64'(miss_count), 64'(exp_misses));
  endtask

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [15:0] wd;
    logic [15:0] rd;
    logic [15:0] ev;
    logic [15:0] fl;
    int          lat;
    int          hits;
    int          misses;
  } vec_t;

  vec_t dir [9];

  initial begin
    int          lat;
    logic [15:0] rd;
    logic [15:0] ev;
    logic [15:0] fl;
    logic [63:0] ln;
    bit          wr;
    logic [15:0] addr;
    logic [15:0] wd;

    dir[0] = '{1'b0, 16'h0001, 16'h0000, 16'h0001, 16'h0000, 16'h0000, 6, 0, 1};
    dir[1] = '{1'b0, 16'h0000, 16'h0000, 16'h9023, 16'h0000, 16'h0000, 0, 1, 1};
    dir[2] = '{1'b0, 16'h0002, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000, 0, 2, 1};
    dir[3] = '{1'b0, 16'h0003, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 3, 1};
    dir[4] = '{1'b1, 16'h0002, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 0, 4, 1};
    dir[5] = '{1'b0, 16'h0010, 16'h0000, 16'hDDDD, 16'h0000, 16'h0010, 12, 4, 2};
    dir[6] = '{1'b1, 16'h0025, 16'hBEEF, 16'h0000, 16'h0000, 16'h0024, 6, 4, 3};
    dir[7] = '{1'b0, 16'h0025, 16'h0000, 16'hBEEF, 16'h0000, 16'h0000, 0, 5, 3};
    dir[8] = '{1'b0, 16'h0035, 16'h0000, 16'h00A9, 16'h0024, 16'h0034, 12, 5, 4};

    for (int i = 0; i < 16384; i++) ref_mem[i] = init_line(i);
    model_reset();

    rst = 1'b1;
    bus.cpu_read    = 1'b0;
    bus.cpu_write   = 1'b0;
    bus.cpu_address = 16'h0000;
    bus.cpu_wdata   = 16'h0000;
    repeat (3) @(negedge clk);
    check("reset_ready", 64'(bus.cpu_ready), 64'd0);
    check("reset_rdata", 64'(bus.cpu_rdata), 64'd0);
    check("reset_readM", 64'(bus.d_readM), 64'd0);
    check("reset_writeM", 64'(bus.d_writeM), 64'd0);
    check("reset_d_address", 64'(bus.d_address), 64'd0);
    check("reset_hits", 64'(hit_count), 64'd0);
    check("reset_misses", 64'(miss_count), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Directed walk: cold load, same-line hits, store hit, dirty eviction, write-allocate.
    for (int i = 0; i < 9; i++) begin
      model_access(dir[i].wr, dir[i].addr, dir[i].wd, lat, rd, ev, fl);
      cpu_op(dir[i].wr, dir[i].addr, dir[i].wd, dir[i].lat, dir[i].rd,
             dir[i].ev, dir[i].fl, dir[i].hits, dir[i].misses);
    end
    check("evicted_line0", mem[0], 64'h0000_1234_0001_9023);
    ln = mem[9];
    check("evicted_line9_word1", 64'(ln[31:16]), 64'h0000_0000_0000_BEEF);

    // No request: ready low and load data held.
    @(negedge clk);
    check("idle_ready", 64'(bus.cpu_ready), 64'd0);
    check("idle_rdata_hold", 64'(bus.cpu_rdata), 64'h00A9);
    @(posedge clk);
    #1;

    // Reset on the third FILL cycle.
    bus.cpu_read    = 1'b1;
    bus.cpu_address = 16'h0001;
    repeat (4) @(negedge clk);
    check("fill_active_before_reset", 64'(bus.d_readM), 64'd1);
    rst = 1'b1;
    #1;
    check("midfill_readM", 64'(bus.d_readM), 64'd0);
    check("midfill_writeM", 64'(bus.d_writeM), 64'd0);
    check("midfill_hits", 64'(hit_count), 64'd0);
    check("midfill_misses", 64'(miss_count), 64'd0);
    check("midfill_ready", 64'(bus.cpu_ready), 64'd0);
    bus.cpu_read = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    model_access(1'b0, 16'h0001, 16'h0000, lat, rd, ev, fl);
    cpu_op(1'b0, 16'h0001, 16'h0000, lat, rd, ev, fl, m_hits, m_misses);

    // Random traffic over a few tags per index to mix hits, clean and dirty misses.
    for (int n = 0; n < 300; n++) begin
      wr   = 1'($urandom_range(0, 1));
      addr = {12'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      wd   = 16'($urandom);
      model_access(wr, addr, wd, lat, rd, ev, fl);
      cpu_op(wr, addr, wd, lat, rd, ev, fl, m_hits, m_misses);
      if (lat == 12) check("writeback_line", mem[ev[15:2]], ref_mem[ev[15:2]]);
    end

    // Counter saturation: a held load to a resident line hits every cycle.
    model_access(1'b0, 16'h0000, 16'h0000, lat, rd, ev, fl);
    cpu_op(1'b0, 16'h0000, 16'h0000, lat, rd, ev, fl, m_hits, m_misses);
    bus.cpu_read    = 1'b1;
    bus.cpu_address = 16'h0000;
    repeat (65540) @(posedge clk);
    #1;
    bus.cpu_read = 1'b0;
    check("hit_count_saturated", 64'(hit_count), 64'hFFFF);
    check("miss_count_after_saturation", 64'(miss_count), 64'(m_misses));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
